// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds a PARITY state to the transmit FSM encoding.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    localparam logic [2:0] TXDATA_OFF = 3'h0;
    localparam logic [2:0] STATUS_OFF = 3'h4;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;
    localparam int ST_CNT   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push on a full FIFO is accepted
// only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop, do_push;

    assign count   = wptr - rptr;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign dout    = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS window on the core store/load port,
// byte FIFO and 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic        hit,
    output logic [31:0] rd_data,
    output logic        txd,
    output logic        tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    // Assert asynchronously, release two edges later so no flop sees a runt edge.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic is_txdata, is_status, wr_txdata, wr_status;
    assign hit       = (Mem_WrAddr[31:3] == BASE_ADDR[31:3]);
    assign is_txdata = ((Mem_WrAddr[2:0] & 3'h4) == TXDATA_OFF);
    assign is_status = ((Mem_WrAddr[2:0] & 3'h4) == STATUS_OFF);
    assign wr_txdata = MemWrite && hit && is_txdata;
    assign wr_status = MemWrite && hit && is_status;

    logic [7:0]  fifo_dout;
    logic        full, empty, pop;
    logic [AW:0] count;
    tx_state_t   state;

    assign pop = (state == IDLE) && !empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (rst_n),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (Mem_WrData[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    logic [7:0]    shift;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            txd     <= 1'b1;
            shift   <= '0;
            baud    <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        shift <= fifo_dout;
                        baud  <= BAUD_MAX;
                        txd   <= 1'b0;
                        state <= START;
`ifdef UART_TX_PARITY_EN
                        par   <= ^fifo_dout;
`endif
                    end
                end
                START: begin
                    if (baud == '0) begin
                        baud    <= BAUD_MAX;
                        bit_idx <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end else baud <= baud - 1'b1;
                end
                DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_MAX;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= par;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end else baud <= baud - 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud == '0) begin
                        baud  <= BAUD_MAX;
                        txd   <= 1'b1;
                        state <= STOP;
                    end else baud <= baud - 1'b1;
                end
`endif
                STOP: begin
                    if (baud == '0) state <= IDLE;
                    else            baud  <= baud - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_busy = (state != IDLE) || !empty;

    // A pop on the same edge frees a slot, so only a stalled full FIFO overflows.
    logic ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                ovf <= 1'b0;
        else if (wr_txdata && full && !pop)        ovf <= 1'b1;
        else if (wr_status && Mem_WrData[ST_OVF])  ovf <= 1'b0;
    end

    logic [31:0] status;
    always_comb begin
        status              = '0;
        status[ST_BUSY]     = tx_busy;
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_OVF]      = ovf;
`ifdef UART_TX_PARITY_EN
        status[ST_PAR]      = 1'b1;
`else
        status[ST_PAR]      = 1'b0;
`endif
        status[ST_CNT +: 8] = 8'(count);
    end

    assign rd_data = (hit && is_status) ? status : '0;

    logic unused_data;
    assign unused_data = ^Mem_WrData[31:8];

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx: a frame-level reference model predicts
// pops and STATUS; a txd monitor decodes frames against a scoreboard.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 16;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int   FRAME   = 11;
    localparam logic PAR_BIT = 1'b1;
`else
    localparam int   FRAME   = 10;
    localparam logic PAR_BIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = '0;
    logic [31:0] Mem_WrData = '0;
    logic        hit, txd, tx_busy;
    logic [31:0] rd_data;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData), .hit(hit), .rd_data(rd_data), .txd(txd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] data; int cyc; } exp_t;
    exp_t       sb[$];
    logic [7:0] mq[$];
    int         cyc = 0;
    int         active_until = 0;
    bit         ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:3] == BASE[31:3];
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (cyc < active_until) || (mq.size() != 0);
        s[1]     = (mq.size() == DEPTH);
        s[2]     = (mq.size() == 0);
        s[3]     = ovf;
        s[4]     = PAR_BIT;
        s[15:8]  = 8'(mq.size());
        return s;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (!m_hit(a)) return '0;
        return a[2] ? m_status() : '0;
    endfunction

    // Reference model: a frame occupies FRAME*CPB edges after its pop, and the
    // next pop can happen on the edge after that.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                mq.delete();
                sb.delete();
                active_until = 0;
                ovf = 1'b0;
            end else begin
                if (mq.size() != 0 && cyc > active_until) begin
                    exp_t e;
                    e.data = mq.pop_front();
                    e.cyc  = cyc;
                    sb.push_back(e);
                    active_until = cyc + FRAME * CPB;
                end
                if (MemWrite && m_hit(Mem_WrAddr)) begin
                    if (!Mem_WrAddr[2]) begin
                        if (mq.size() < DEPTH) mq.push_back(Mem_WrData[7:0]);
                        else                   ovf = 1'b1;
                    end else if (Mem_WrData[3]) ovf = 1'b0;
                end
            end
        end
    end

    // Serial monitor: samples each bit mid-period and checks against the scoreboard.
    bit         mon_active = 1'b0;
    bit         cur_valid = 1'b0;
    int         mcnt = 0;
    logic [7:0] mbyte = '0;
    exp_t       cur;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) mon_active = 1'b0;
            else if (!mon_active) begin
                if (txd === 1'b0) begin
                    mon_active = 1'b1;
                    mcnt  = 0;
                    mbyte = '0;
                    if (sb.size() == 0) begin
                        cur_valid = 1'b0;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                    end else begin
                        cur = sb.pop_front();
                        cur_valid = 1'b1;
                        chk("start_cycle", cyc, cur.cyc);
                    end
                end
            end else begin
                mcnt++;
                if (mcnt % CPB == CPB / 2) begin
                    int k;
                    k = mcnt / CPB;
                    if (k == 0) chk("start_bit", txd, 0);
                    else if (k <= 8) mbyte[k-1] = txd;
                    else if (k == FRAME - 1) begin
                        chk("stop_bit", txd, 1);
                        if (cur_valid) chk("frame_data", mbyte, cur.data);
                        mon_active = 1'b0;
                    end else if (cur_valid) chk("parity_bit", txd, ^cur.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            MemWrite = 1'b0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1;
        Mem_WrAddr = a;
        Mem_WrData = d;
    endtask

    task automatic rd(input string nm, input logic [31:0] a);
        @(negedge clk);
        MemWrite = 1'b0;
        Mem_WrAddr = a;
        Mem_WrData = $urandom();
        #1;
        chk({nm, "_hit"}, hit, m_hit(a));
        chk({nm, "_rd"}, rd_data, m_rd(a));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || mq.size() != 0 || mon_active || cyc < active_until) && n < 30000) begin
            @(negedge clk);
            MemWrite = 1'b0;
            n++;
        end
        chk("drain_in_time", n < 30000, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        idle(3);
        chk("reset_txd", txd, 1);
        chk("reset_busy", tx_busy, 0);
        @(negedge clk) reset = 1'b1;
        idle(4);
        chk("idle_txd", txd, 1);
        chk("idle_busy", tx_busy, 0);
        rd("status_reset", BASE + 4);
        chk("status_reset_val", rd_data, {27'b0, PAR_BIT, 4'h4});

        // Single frame
        wr(BASE, 32'h0000_00A5);
        idle(1);
        chk("busy_after_store", tx_busy, 1);
        drain();
        chk("busy_after_frame", tx_busy, 0);

        // Back-to-back frames
        wr(BASE, 32'h11);
        wr(BASE, 32'h22);
        wr(BASE, 32'h33);
        rd("status_b2b", BASE + 4);
        chk("count_after_pop", rd_data[15:8], 2);
        drain();

        // Overflow, clear, then a store on a full FIFO coinciding with a pop
        for (int i = 0; i < 10; i++) wr(BASE, 32'h40 + i);
        rd("status_ovf", BASE + 4);
        chk("ovf_full_bits", rd_data[3:0], 4'hB);
        chk("ovf_count", rd_data[15:8], 8);
        wr(BASE + 4, 32'h8);
        rd("status_clr", BASE + 4);
        chk("ovf_cleared", rd_data[3], 0);
        begin
            int n;
            n = 0;
            while (cyc != active_until - 1 && n < 1000) begin
                @(negedge clk);
                MemWrite = 1'b0;
                n++;
            end
            chk("pop_edge_found", n < 1000, 1);
        end
        wr(BASE, 32'h3C);
        rd("status_full_pop", BASE + 4);
        chk("full_pop_no_ovf", rd_data[3], 0);
        chk("full_pop_count", rd_data[15:8], 8);
        drain();

        // Window decode and aliases
        wr(BASE + 8, 32'h99);
        rd("outside", BASE + 8);
        chk("outside_hit", hit, 0);
        chk("outside_rd", rd_data, 0);
        rd("txdata_alias", BASE + 1);
        rd("status_alias", BASE + 6);
        chk("no_enqueue_outside", rd_data[15:8], 0);
        wr(BASE + 3, 32'h07);
        drain();

        // Reset during DATA bit 3
        wr(BASE, 32'hA5);
        idle(70);
        #2 reset = 1'b0;
        #1;
        chk("midframe_reset_txd", txd, 1);
        chk("midframe_reset_busy", tx_busy, 0);
        rd("status_in_reset", BASE + 4);
        @(negedge clk) reset = 1'b1;
        idle(4);
        wr(BASE, 32'h5C);
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 20)      wr(BASE + $urandom_range(0, 3), $urandom());
            else if (r < 35) rd("rnd_status", BASE + 4 + $urandom_range(0, 3));
            else if (r < 40) rd("rnd_txdata", BASE + $urandom_range(0, 3));
            else if (r < 43) wr(BASE + 4, $urandom());
            else if (r < 46) wr($urandom(), $urandom());
            else if (r < 48) rd("rnd_addr", BASE + 8 + $urandom_range(0, 7));
            else             idle($urandom_range(1, 30));
        end
        idle(1);
        drain();
        rd("status_final", BASE + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
